// File: rtl/fp_norm_pkg.sv
// Shared types and widths for the floating-point normalize/round block.
// The state enum is here so the bench can decode the debug state port.
package fp_norm_pkg;
  localparam int MANT_W  = 28;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int IEXP_W  = 10;

  localparam logic signed [IEXP_W-1:0] EXP_MAX_S = 10'sd255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_ROUND = 3'd2,
    S_PACK  = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/fp_normalize_round_if.sv
// Raw-sum input and packed-result output bundle for fp_normalize_round.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1; the source holds its payload stable while valid is high and ready is low.
interface fp_normalize_round_if;
  import fp_norm_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the hidden-one and fraction/GRS bits.
// Counts from bit 26 downward; an all-zero input reports 27.
module fp_lzc (
  input  logic [26:0] i_bits,
  output logic [4:0]  o_count
);
  always_comb begin
    o_count = 5'd27;
    // Later iterations are higher bits, so the highest set bit wins.
    for (int i = 0; i < 27; i++) begin
      if (i_bits[i]) o_count = 5'(26 - i);
    end
  end
endmodule

// File: rtl/fp_normalize_round.sv
// Normalizes an unnormalized single-precision sum, rounds to nearest-even and
// packs it, one step per state: IDLE -> NORM -> ROUND -> PACK -> DONE.
module fp_normalize_round
  import fp_norm_pkg::*;
(
  input  logic                clk,
  input  logic                res,
  fp_normalize_round_if.slave bus,
  output state_t              o_dbg_state
);
  state_t                   r_state;
  logic                     r_sign;
  logic                     r_zero;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_ovf;
  logic                     r_unf;
  logic signed [IEXP_W-1:0] r_exp;
  logic [MANT_W-1:0]        r_mant;
  logic [31:0]              r_result;

  logic [4:0]               w_lz;
  logic [MANT_W-1:0]        w_norm_mant;
  logic signed [IEXP_W-1:0] w_norm_exp;
  logic                     w_round_up;
  logic [FRAC_W+1:0]        w_round_sum;
  logic [MANT_W-1:0]        w_round_mant;
  logic signed [IEXP_W-1:0] w_round_exp;

  fp_lzc u_lzc (
    .i_bits  (r_mant[MANT_W-2:0]),
    .o_count (w_lz)
  );

  // Carry case folds the two dropped bits into sticky so rounding stays exact.
  always_comb begin
    w_norm_mant = r_mant;
    w_norm_exp  = r_exp;
    if (r_mant[MANT_W-1]) begin
      w_norm_mant = {1'b0, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};
      w_norm_exp  = r_exp + 10'sd1;
    end else begin
      w_norm_mant = r_mant << w_lz;
      w_norm_exp  = r_exp - $signed({5'b0, w_lz});
    end
  end

  assign w_round_up  = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
  assign w_round_sum = {1'b0, r_mant[26:3]} + {{FRAC_W+1{1'b0}}, w_round_up};

  always_comb begin
    w_round_mant = {1'b0, w_round_sum[FRAC_W:0], 3'b000};
    w_round_exp  = r_exp;
    if (w_round_sum[FRAC_W+1]) begin
      w_round_mant = {1'b0, w_round_sum[FRAC_W+1:1], 3'b000};
      w_round_exp  = r_exp + 10'sd1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_exp       <= '0;
      r_mant      <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_sign     <= bus.in_sign;
            r_exp      <= $signed({2'b00, bus.in_exp});
            r_mant     <= bus.in_mant;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_mant == '0) begin
            r_zero <= 1'b1;
          end else if (w_norm_exp <= 10'sd0) begin
            r_zero <= 1'b1;
            r_unf  <= 1'b1;
            r_mant <= '0;
            r_exp  <= w_norm_exp;
          end else begin
            r_mant <= w_norm_mant;
            r_exp  <= w_norm_exp;
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (!r_zero) begin
            r_mant <= w_round_mant;
            r_exp  <= w_round_exp;
          end
          r_state <= S_PACK;
        end
        S_PACK: begin
          if (r_zero) begin
            r_result <= {r_sign, 31'b0};
          end else if (r_exp >= EXP_MAX_S) begin
            r_result <= {r_sign, 8'hFF, 23'b0};
            r_ovf    <= 1'b1;
          end else begin
            r_result <= {r_sign, r_exp[EXP_W-1:0], r_mant[25:3]};
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_result    = r_result;
  assign bus.out_overflow  = r_ovf;
  assign bus.out_underflow = r_unf;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized bench for fp_normalize_round: driver pushes expected results from an
// arithmetic rounding model, a monitor pops and compares whenever out_valid is high.
module tb_fp_normalize_round;
  import fp_norm_pkg::*;

  logic   clk;
  logic   res;
  state_t dbg_state;
  int     checks;
  int     errors;
  int     cycle_cnt;
  int     stall_req;
  bit     have_cur;

  logic [33:0] exp_q[$];
  int          acc_q[$];

  fp_normalize_round_if bus ();

  fp_normalize_round dut (
    .clk         (clk),
    .res         (res),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Exact round-to-nearest-even of the raw sum to a 24-bit significand.
  function automatic logic [33:0] model(input logic s, input logic [7:0] e8, input logic [27:0] m);
    longint mv, q, rem, half;
    int p, e, sh;
    if (m == 28'd0) return {2'b00, s, 31'b0};
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    e = int'(e8) + p - 26;
    if (e <= 0) return {2'b01, s, 31'b0};
    mv = longint'(m);
    sh = p - 23;
    if (sh > 0) begin
      q    = mv >> sh;
      rem  = mv & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mv << (-sh);
    end
    if (q == (64'sd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= EXP_MAX) return {2'b10, s, 8'hFF, 23'b0};
    return {2'b00, s, e[7:0], q[22:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m, input bit push);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (push) begin
      exp_q.push_back(model(s, e, m));
      acc_q.push_back(cycle_cnt);
    end
    check("in_ready_busy", {33'b0, bus.in_ready}, 34'd0);
    @(negedge clk);
  endtask

  task automatic send_rand();
    logic [27:0] m;
    logic [7:0]  e;
    int p;
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) begin
      m = 28'd0;
    end else if (r == 1) begin
      m = 28'h7FFFFFF;
    end else begin
      p = $urandom_range(0, 27);
      m = 28'($urandom());
      m = (m & ((28'h1 << p) - 28'h1)) | (28'h1 << p);
      if ($urandom_range(0, 3) == 0) m[2:0] = 3'b100;
    end
    case ($urandom_range(0, 3))
      0:       e = 8'($urandom_range(0, 8));
      1:       e = 8'($urandom_range(245, 255));
      default: e = 8'($urandom_range(0, 255));
    endcase
    send(1'($urandom_range(0, 1)), e, m, 1'b1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [33:0] cur;
    int  acc;
    int  stall_left;
    bit  hs_prev;
    bit  unexp;
    have_cur       = 1'b0;
    hs_prev        = 1'b0;
    unexp          = 1'b0;
    stall_left     = 0;
    cur            = '0;
    bus.out_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (res) begin
        have_cur      = 1'b0;
        hs_prev       = 1'b0;
        bus.out_ready = 1'b0;
        continue;
      end
      if (hs_prev) begin
        check("return_idle", {32'b0, bus.in_ready, bus.out_valid}, 34'b10);
        hs_prev = 1'b0;
      end
      if (bus.out_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            unexp = 1'b1;
            $display("FAIL unexpected_output actual=%h required=none", bus.out_result);
          end else begin
            unexp = 1'b0;
            cur   = exp_q.pop_front();
            acc   = acc_q.pop_front();
            check("latency", 34'(cycle_cnt - acc), 34'd3);
          end
          have_cur   = 1'b1;
          stall_left = stall_req;
          stall_req  = 0;
        end
        if (!unexp)
          check("result", {bus.out_overflow, bus.out_underflow, bus.out_result}, cur);
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (bus.out_ready) begin
          hs_prev  = 1'b1;
          have_cur = 1'b0;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    checks       = 0;
    errors       = 0;
    cycle_cnt    = 0;
    stall_req    = 0;
    res          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = '0;
    bus.in_mant  = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {33'b0, bus.in_ready}, 34'd1);
    check("rst_out_valid", {33'b0, bus.out_valid}, 34'd0);
    check("rst_result",    {2'b00, bus.out_result}, 34'd0);
    check("rst_flags",     {32'b0, bus.out_overflow, bus.out_underflow}, 34'd0);
    check("rst_state",     34'(dbg_state), 34'(S_IDLE));
    res = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    send(1'b0, 8'h80, 28'h4000000, 1'b1);
    send(1'b0, 8'(BIAS), 28'h8000000, 1'b1);
    send(1'b0, 8'hFE, 28'h8000000, 1'b1);
    send(1'b0, 8'h85, 28'h0400000, 1'b1);
    send(1'b0, 8'h03, 28'h0400000, 1'b1);
    send(1'b0, 8'(BIAS), 28'h400000C, 1'b1);
    send(1'b0, 8'(BIAS), 28'h4000004, 1'b1);
    send(1'b1, 8'h55, 28'h7FFFFFF, 1'b1);
    send(1'b0, 8'h00, 28'h8000001, 1'b1);
    send(1'b1, 8'h10, 28'h0000000, 1'b1);
    stall_req = 5;

    // Reset while the transaction sits in ROUND; it must vanish.
    send(1'b0, 8'h90, 28'h5555555, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset_state", 34'(dbg_state), 34'(S_ROUND));
    res = 1'b1;
    #1;
    check("midrst_out_valid", {33'b0, bus.out_valid}, 34'd0);
    check("midrst_in_ready",  {33'b0, bus.in_ready}, 34'd1);
    check("midrst_state",     34'(dbg_state), 34'(S_IDLE));
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    send(1'b0, 8'h80, 28'h4000000, 1'b1);

    for (int i = 0; i < 300; i++) send_rand();

    n = 0;
    while ((exp_q.size() != 0 || have_cur) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || have_cur) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
